ref_clk_train_ctrl: RTL

Multi-lane reference-clock training sequencer for the DDR4 PHY block. It drives the dynamic delay-line and eye-monitor controls of up to `N_LANES` reference-clock input IODs. For each enabled lane it sweeps the receive delay across all taps, finds the widest passing window from the EARLY/LATE flags, and parks the delay line at the centre of that window. Per-lane pass/fail, final tap and eye width go to the training/status logic on the fabric clock.

---
 rtl/ref_clk_train_ctrl_if.sv | 39 +++
 rtl/ref_clk_train_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ref_clk_train_ctrl_if.sv
// Handshake and per-lane IOD control bundle for the reference-clock training sequencer.
// master = training requester / IOD side, slave = sequencer.
interface ref_clk_train_ctrl_if #(
    parameter int N_LANES  = 4,
    parameter int DLY_TAPS = 128
);
    localparam int TW = $clog2(DLY_TAPS) + 1;

    logic                    TRAIN_START;
    logic [N_LANES-1:0]      TRAIN_LANE_MASK;
    logic [N_LANES-1:0]      EYE_MONITOR_EARLY;
    logic [N_LANES-1:0]      EYE_MONITOR_LATE;
    logic [N_LANES-1:0]      DELAY_LINE_OUT_OF_RANGE;
    logic [N_LANES-1:0]      DELAY_LINE_MOVE;
    logic [N_LANES-1:0]      DELAY_LINE_DIRECTION;
    logic [N_LANES-1:0]      DELAY_LINE_LOAD;
    logic [N_LANES-1:0]      EYE_MONITOR_CLEAR_FLAGS;
    logic                    TRAIN_BUSY;
    logic                    TRAIN_DONE;
    logic [N_LANES-1:0]      TRAIN_PASS;
    logic [N_LANES*TW-1:0]   LANE_TAP;
    logic [N_LANES*TW-1:0]   LANE_EYE_WIDTH;

    modport master (
        output TRAIN_START, TRAIN_LANE_MASK, EYE_MONITOR_EARLY, EYE_MONITOR_LATE,
               DELAY_LINE_OUT_OF_RANGE,
        input  DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD,
               EYE_MONITOR_CLEAR_FLAGS, TRAIN_BUSY, TRAIN_DONE, TRAIN_PASS,
               LANE_TAP, LANE_EYE_WIDTH
    );

    modport slave (
        input  TRAIN_START, TRAIN_LANE_MASK, EYE_MONITOR_EARLY, EYE_MONITOR_LATE,
               DELAY_LINE_OUT_OF_RANGE,
        output DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD,
               EYE_MONITOR_CLEAR_FLAGS, TRAIN_BUSY, TRAIN_DONE, TRAIN_PASS,
               LANE_TAP, LANE_EYE_WIDTH
    );
endinterface

// File: rtl/ref_clk_train_ctrl.sv
// Reference-clock training sequencer: per lane, sweeps the delay line over all taps,
// tracks the widest passing window from the eye-monitor flags and parks at its centre.
module ref_clk_train_ctrl #(
    parameter int N_LANES    = 4,
    parameter int DLY_TAPS   = 128,
    parameter int SETTLE_CYC = 8,
    parameter int SAMPLE_CYC = 16,
    parameter int MIN_EYE    = 4
) (
    input logic FAB_CLK,
    input logic ARST,
    ref_clk_train_ctrl_if.slave bus
);
    localparam int TW = $clog2(DLY_TAPS) + 1;
    localparam int LW = (N_LANES > 1) ? $clog2(N_LANES) : 1;
    localparam int CW = 16;
    localparam logic [N_LANES-1:0] LANE_ONE = N_LANES'(1);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_SETTLE, S_CLEAR, S_SAMPLE, S_EVAL, S_MOVE, S_CENTER, S_NEXT, S_DONE
    } state_t;

    state_t                state_q;
    logic [LW-1:0]         lane_q;
    logic [N_LANES-1:0]    mask_q;
    logic [TW-1:0]         tap_q, target_q;
    logic [CW-1:0]         cnt_q;
    logic                  fail_q, open_q, cphase_q;
    logic [TW-1:0]         cur_start_q, cur_w_q, best_start_q, best_w_q;
    logic [N_LANES-1:0]    move_q, dir_q, load_q, clr_q, pass_q;
    logic                  busy_q, done_q;
    logic [N_LANES*TW-1:0] lane_tap_q, lane_w_q;

    logic [TW-1:0]         cur_start_d, cur_w_d, best_start_d, best_w_d, target_d;
    logic                  open_d, close_c, sweep_end;
    logic [N_LANES-1:0]    lane_oh, scan_mask;
    int unsigned           scan_from;
    logic                  found;
    logic [LW-1:0]         nxt_lane;

    assign bus.DELAY_LINE_MOVE         = move_q;
    assign bus.DELAY_LINE_DIRECTION    = dir_q;
    assign bus.DELAY_LINE_LOAD         = load_q;
    assign bus.EYE_MONITOR_CLEAR_FLAGS = clr_q;
    assign bus.TRAIN_BUSY              = busy_q;
    assign bus.TRAIN_DONE              = done_q;
    assign bus.TRAIN_PASS              = pass_q;
    assign bus.LANE_TAP                = lane_tap_q;
    assign bus.LANE_EYE_WIDTH          = lane_w_q;

    assign lane_oh = LANE_ONE << lane_q;

    // Lowest enabled lane at or above scan_from; masked lanes cost no cycles.
    always_comb begin
        scan_mask = (state_q == S_IDLE) ? bus.TRAIN_LANE_MASK : mask_q;
        scan_from = (state_q == S_IDLE) ? 0 : int'(unsigned'(lane_q)) + 1;
        found     = 1'b0;
        nxt_lane  = '0;
        for (int unsigned i = 0; i < N_LANES; i++) begin
            if (!found && scan_mask[i] && i >= scan_from) begin
                found    = 1'b1;
                nxt_lane = LW'(i);
            end
        end
    end

    // Window bookkeeping for the tap just sampled; a window still open at sweep end is closed here too.
    always_comb begin
        sweep_end    = (tap_q == TW'(DLY_TAPS - 1)) || bus.DELAY_LINE_OUT_OF_RANGE[lane_q];
        cur_start_d  = cur_start_q;
        cur_w_d      = cur_w_q;
        open_d       = open_q;
        best_start_d = best_start_q;
        best_w_d     = best_w_q;
        close_c      = 1'b0;
        if (!fail_q) begin
            if (!open_q) begin
                cur_start_d = tap_q;
                cur_w_d     = TW'(1);
                open_d      = 1'b1;
            end else begin
                cur_w_d = cur_w_q + 1'b1;
            end
            close_c = sweep_end;
        end else begin
            close_c = open_q;
        end
        if (close_c) begin
            open_d = 1'b0;
            if (cur_w_d > best_w_q) begin
                best_start_d = cur_start_d;
                best_w_d     = cur_w_d;
            end
        end
        target_d = best_start_d + (best_w_d >> 1);
    end

    always_ff @(posedge FAB_CLK or posedge ARST) begin
        if (ARST) begin
            state_q      <= S_IDLE;
            lane_q       <= '0;
            mask_q       <= '0;
            tap_q        <= '0;
            target_q     <= '0;
            cnt_q        <= '0;
            fail_q       <= 1'b0;
            open_q       <= 1'b0;
            cphase_q     <= 1'b0;
            cur_start_q  <= '0;
            cur_w_q      <= '0;
            best_start_q <= '0;
            best_w_q     <= '0;
            move_q       <= '0;
            dir_q        <= '0;
            load_q       <= '0;
            clr_q        <= '0;
            pass_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            lane_tap_q   <= '0;
            lane_w_q     <= '0;
        end else begin
            move_q <= '0;
            dir_q  <= '0;
            load_q <= '0;
            clr_q  <= '0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: if (bus.TRAIN_START) begin
                    mask_q     <= bus.TRAIN_LANE_MASK;
                    pass_q     <= '0;
                    lane_tap_q <= '0;
                    lane_w_q   <= '0;
                    if (found) begin
                        busy_q  <= 1'b1;
                        lane_q  <= nxt_lane;
                        load_q  <= LANE_ONE << nxt_lane;
                        state_q <= S_LOAD;
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_LOAD: begin
                    tap_q        <= '0;
                    open_q       <= 1'b0;
                    cur_start_q  <= '0;
                    cur_w_q      <= '0;
                    best_start_q <= '0;
                    best_w_q     <= '0;
                    cnt_q        <= '0;
                    state_q      <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (cnt_q == CW'(SETTLE_CYC - 1)) begin
                        clr_q   <= lane_oh;
                        state_q <= S_CLEAR;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_CLEAR: begin
                    fail_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= S_SAMPLE;
                end
                S_SAMPLE: begin
                    fail_q <= fail_q | bus.EYE_MONITOR_EARLY[lane_q] | bus.EYE_MONITOR_LATE[lane_q];
                    if (cnt_q == CW'(SAMPLE_CYC - 1)) state_q <= S_EVAL;
                    else                               cnt_q   <= cnt_q + 1'b1;
                end
                S_EVAL: begin
                    cur_start_q  <= cur_start_d;
                    cur_w_q      <= cur_w_d;
                    open_q       <= open_d;
                    best_start_q <= best_start_d;
                    best_w_q     <= best_w_d;
                    if (sweep_end) begin
                        target_q <= target_d;
                        cphase_q <= 1'b0;
                        state_q  <= S_CENTER;
                    end else begin
                        move_q  <= lane_oh;
                        dir_q   <= lane_oh;
                        tap_q   <= tap_q + 1'b1;
                        state_q <= S_MOVE;
                    end
                end
                S_MOVE: begin
                    cnt_q   <= '0;
                    state_q <= S_SETTLE;
                end
                // cphase_q marks the cycle the decrement pulse is on the line; the next is its idle slot.
                S_CENTER: begin
                    if (cphase_q) begin
                        cphase_q <= 1'b0;
                    end else if (best_w_q < TW'(MIN_EYE)) begin
                        load_q                          <= lane_oh;
                        pass_q[lane_q]                  <= 1'b0;
                        lane_tap_q[int'(lane_q)*TW +: TW] <= '0;
                        lane_w_q[int'(lane_q)*TW +: TW]   <= best_w_q;
                        state_q                         <= S_NEXT;
                    end else if (tap_q != target_q) begin
                        move_q   <= lane_oh;
                        tap_q    <= tap_q - 1'b1;
                        cphase_q <= 1'b1;
                    end else begin
                        pass_q[lane_q]                  <= 1'b1;
                        lane_tap_q[int'(lane_q)*TW +: TW] <= target_q;
                        lane_w_q[int'(lane_q)*TW +: TW]   <= best_w_q;
                        state_q                         <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (found) begin
                        lane_q  <= nxt_lane;
                        load_q  <= LANE_ONE << nxt_lane;
                        state_q <= S_LOAD;
                    end else begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule
